// File: rtl/l1mtx_pkg.sv
// Shared L1MTX definitions: AHB HTRANS/HBURST encodings and the burst beat-count helper.
package l1mtx_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] BURST_WRAP4  = 3'b010;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] BURST_WRAP8  = 3'b100;
    localparam logic [2:0] BURST_INCR8  = 3'b101;
    localparam logic [2:0] BURST_WRAP16 = 3'b110;
    localparam logic [2:0] BURST_INCR16 = 3'b111;

    localparam int unsigned BEAT_W = 5;

    // Beats still owed after the NONSEQ beat of a defined-length burst.
    function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] burst);
        case (burst)
            BURST_WRAP4,  BURST_INCR4:  return BEAT_W'(3);
            BURST_WRAP8,  BURST_INCR8:  return BEAT_W'(7);
            BURST_WRAP16, BURST_INCR16: return BEAT_W'(15);
            default:                    return '0;
        endcase
    endfunction

endpackage

// File: rtl/l1mtx_out_arb_if.sv
// Request/select bundle between the input stages and one output-stage arbiter.
interface l1mtx_out_arb_if #(
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned IDX_W  = $clog2(NUM_IN)
);
    logic                  HREADYM;
    logic [NUM_IN-1:0]     sel_op;
    logic [2*NUM_IN-1:0]   trans_op;
    logic [3*NUM_IN-1:0]   burst_op;
    logic [NUM_IN-1:0]     mastlock_op;
    logic [IDX_W-1:0]      addr_in_port;
    logic                  no_port;
    logic [NUM_IN-1:0]     active_op;
    logic [IDX_W-1:0]      data_in_port;
    logic                  data_valid;

    modport slave (
        input  HREADYM, sel_op, trans_op, burst_op, mastlock_op,
        output addr_in_port, no_port, active_op, data_in_port, data_valid
    );

    modport master (
        output HREADYM, sel_op, trans_op, burst_op, mastlock_op,
        input  addr_in_port, no_port, active_op, data_in_port, data_valid
    );
endinterface

// File: rtl/l1mtx_rr_pick.sv
// Combinational round-robin pick: first set req bit after ptr, wrapping modulo NUM_IN.
module l1mtx_rr_pick #(
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);
    int unsigned j;

    // Scan farthest-to-nearest so the nearest requester after ptr wins.
    always_comb begin
        idx = '0;
        any = |req;
        j   = 0;
        for (int unsigned k = NUM_IN; k >= 1; k--) begin
            j = (32'(ptr) + k) % NUM_IN;
            if (req[j]) begin
                idx = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/l1mtx_out_arb.sv
// Round-robin arbiter for one L1MTX output port. Holds the grant across SEQ/BUSY
// beats and locked sequences. Optional macro L1MTX_ARB_BURST_HOLD_EN adds a beat
// counter so defined-length bursts cannot be interleaved even across IDLE beats.
module l1mtx_out_arb
    import l1mtx_pkg::*;
#(
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned IDX_W  = $clog2(NUM_IN)
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    l1mtx_out_arb_if.slave   bus
);
    localparam int unsigned NUM_PAD = 1 << IDX_W;

    logic [IDX_W-1:0]   grant_q;
    logic               owned_q;
    logic               lock_q;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   data_port_q;
    logic               data_valid_q;

    logic [NUM_PAD-1:0] sel_pad;
    logic [NUM_PAD-1:0] lock_pad;
    logic [1:0]         trans_pad [NUM_PAD];
    logic [NUM_IN-1:0]  req;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               owner_sel;
    logic [1:0]         owner_trans;
    logic               burst_hold;
    logic               hold;
    logic               new_grant;
    logic [IDX_W-1:0]   addr_idx;
    logic               no_own;
    logic [NUM_IN-1:0]  active;

    // Unpack per-input fields into power-of-two arrays so any index value is in range.
    always_comb begin
        sel_pad  = '0;
        lock_pad = '0;
        req      = '0;
        for (int unsigned i = 0; i < NUM_PAD; i++) begin
            trans_pad[i] = TRANS_IDLE;
        end
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            sel_pad[i]   = bus.sel_op[i];
            lock_pad[i]  = bus.mastlock_op[i];
            trans_pad[i] = bus.trans_op[2*i +: 2];
            req[i]       = bus.sel_op[i] & bus.trans_op[2*i+1];
        end
    end

    l1mtx_rr_pick #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef L1MTX_ARB_BURST_HOLD_EN
    logic [2:0]        burst_pad [NUM_PAD];
    logic [BEAT_W-1:0] cnt_q;

    // Burst type per input, padded like the other per-input arrays.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PAD; i++) begin
            burst_pad[i] = BURST_SINGLE;
        end
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            burst_pad[i] = bus.burst_op[3*i +: 3];
        end
    end

    // Beats remaining in the owner's defined-length burst.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else if (bus.HREADYM) begin
            if (new_grant) begin
                cnt_q <= burst_beats(burst_pad[addr_idx]);
            end else if (no_own) begin
                cnt_q <= '0;
            end else if (owner_trans == TRANS_SEQ && cnt_q != '0) begin
                cnt_q <= cnt_q - BEAT_W'(1);
            end
        end
    end

    assign burst_hold = (cnt_q != '0);
`else
    logic unused_burst;
    assign unused_burst = ^bus.burst_op;
    assign burst_hold   = 1'b0;
`endif

    // Hold/re-arbitrate decision and the combinational address-phase owner.
    always_comb begin
        owner_sel   = sel_pad[grant_q];
        owner_trans = trans_pad[grant_q];
        hold        = owned_q & owner_sel &
                      ((owner_trans == TRANS_BUSY) | (owner_trans == TRANS_SEQ) |
                       lock_q | burst_hold);
        new_grant   = ~hold & pick_any;
        addr_idx    = new_grant ? pick_idx : grant_q;
        no_own      = ~hold & ~pick_any;
        active      = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            active[i] = ~no_own & (addr_idx == IDX_W'(i));
        end
    end

    // Grant, lock, round-robin pointer and data-phase owner advance on ready edges.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q      <= '0;
            owned_q      <= 1'b0;
            lock_q       <= 1'b0;
            rr_ptr       <= '0;
            data_port_q  <= '0;
            data_valid_q <= 1'b0;
        end else if (bus.HREADYM) begin
            grant_q      <= addr_idx;
            owned_q      <= ~no_own;
            lock_q       <= lock_pad[addr_idx] & ~no_own;
            data_port_q  <= addr_idx;
            data_valid_q <= ~no_own;
            if (new_grant) begin
                rr_ptr <= addr_idx;
            end
        end
    end

    assign bus.addr_in_port = addr_idx;
    assign bus.no_port      = no_own;
    assign bus.active_op    = active;
    assign bus.data_in_port = data_port_q;
    assign bus.data_valid   = data_valid_q;
endmodule

// File: tb/tb_l1mtx_out_arb.sv
// Testbench for l1mtx_out_arb: directed scenarios plus random traffic against a
// behavioural arbitration model.
module tb_l1mtx_out_arb;
    import l1mtx_pkg::*;

    localparam int N  = 3;
    localparam int IW = 2;
`ifdef L1MTX_ARB_BURST_HOLD_EN
    localparam bit BH = 1'b1;
`else
    localparam bit BH = 1'b0;
`endif

    logic HCLK;
    logic HRESETn;

    l1mtx_out_arb_if #(.NUM_IN(N), .IDX_W(IW)) bus ();

    l1mtx_out_arb #(.NUM_IN(N), .IDX_W(IW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_grant, m_ptr, m_cnt, m_dport;
    bit m_owned, m_lock, m_dvalid;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] trans_of(input int i);
        return bus.trans_op[2*i +: 2];
    endfunction

    function automatic int beats_of(input int i);
        int len [8] = '{1, 1, 4, 4, 8, 8, 16, 16};
        return len[bus.burst_op[3*i +: 3]] - 1;
    endfunction

    function automatic void model_reset();
        m_grant = 0; m_ptr = 0; m_cnt = 0; m_dport = 0;
        m_owned = 0; m_lock = 0; m_dvalid = 0;
    endfunction

    // Who owns the address phase this cycle according to the arbitration rules.
    function automatic void model_next(output int idx, output bit none, output bit fresh);
        bit hold;
        logic [1:0] ot;
        ot    = trans_of(m_grant);
        hold  = m_owned && bus.sel_op[m_grant] &&
                (ot == TRANS_BUSY || ot == TRANS_SEQ || m_lock || (BH && m_cnt > 0));
        idx   = m_grant;
        none  = 1'b1;
        fresh = 1'b0;
        if (hold) begin
            none = 1'b0;
            return;
        end
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (bus.sel_op[i] && (trans_of(i) == TRANS_NONSEQ || trans_of(i) == TRANS_SEQ)) begin
                idx   = i;
                none  = 1'b0;
                fresh = 1'b1;
                return;
            end
        end
    endfunction

    function automatic void model_update(input int idx, input bit none, input bit fresh);
        if (fresh) m_cnt = beats_of(idx);
        else if (none) m_cnt = 0;
        else if (trans_of(m_grant) == TRANS_SEQ && m_cnt > 0) m_cnt = m_cnt - 1;
        if (fresh) m_ptr = idx;
        m_grant  = idx;
        m_owned  = !none;
        m_lock   = bus.mastlock_op[idx] && !none;
        m_dport  = idx;
        m_dvalid = !none;
    endfunction

    task automatic drive(input int i, input bit sel, input logic [1:0] trans,
                         input logic [2:0] burst, input bit lock);
        bus.sel_op[i]         = sel;
        bus.trans_op[2*i +: 2] = trans;
        bus.burst_op[3*i +: 3] = burst;
        bus.mastlock_op[i]    = lock;
    endtask

    task automatic clear_inputs();
        bus.sel_op      = '0;
        bus.trans_op    = '0;
        bus.burst_op    = '0;
        bus.mastlock_op = '0;
        bus.HREADYM     = 1'b1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        model_reset();
    endtask

    // One clock: compare against the model at negedge, then advance the model at the edge.
    task automatic cycle(input string tag, output int a, output bit n, output int dp, output bit dv);
        int ei;
        bit en, ef;
        logic [N-1:0] eact;
        @(negedge HCLK);
        model_next(ei, en, ef);
        eact = '0;
        if (!en) eact[ei] = 1'b1;
        a  = int'(bus.addr_in_port);
        n  = bus.no_port;
        dp = int'(bus.data_in_port);
        dv = bus.data_valid;
        checks++;
        if (bus.no_port !== en || a !== ei) begin
            errors++;
            $display("FAIL %s addr: addr_in_port=%0d no_port=%0b, expected %0d/%0b", tag, a, n, ei, en);
        end
        checks++;
        if (bus.active_op !== eact) begin
            errors++;
            $display("FAIL %s active_op: got %b expected %b", tag, bus.active_op, eact);
        end
        checks++;
        if (bus.data_valid !== m_dvalid || (m_dvalid && dp !== m_dport)) begin
            errors++;
            $display("FAIL %s data: data_in_port=%0d data_valid=%0b, expected %0d/%0b",
                     tag, dp, dv, m_dport, m_dvalid);
        end
        @(posedge HCLK);
        if (HRESETn && bus.HREADYM) model_update(ei, en, ef);
        #1;
    endtask

    task automatic test_reset();
        int a, dp;
        bit n, dv;
        HRESETn = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        checks++;
        if (bus.no_port !== 1'b1 || bus.active_op !== '0 || bus.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: no_port=%0b active_op=%b data_valid=%0b, expected 1/000/0",
                     bus.no_port, bus.active_op, bus.data_valid);
        end
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        cycle("reset_idle", a, n, dp, dv);
        checks++;
        if (bus.no_port !== 1'b1 || bus.active_op !== '0 || bus.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge: no_port=%0b active_op=%b data_valid=%0b, expected 1/000/0",
                     bus.no_port, bus.active_op, bus.data_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq [6] = '{1, 2, 0, 1, 2, 0};
        int a, dp;
        bit n, dv;
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, TRANS_NONSEQ, BURST_SINGLE, 1'b0);
        for (int c = 0; c < 6; c++) begin
            cycle("round_robin", a, n, dp, dv);
            checks++;
            if (a !== exp_seq[c] || n !== 1'b0) begin
                errors++;
                $display("FAIL rr_grant[%0d]: addr_in_port=%0d expected %0d", c, a, exp_seq[c]);
            end
            if (c > 0) begin
                checks++;
                if (dp !== exp_seq[c-1] || dv !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_data[%0d]: data_in_port=%0d expected %0d", c, dp, exp_seq[c-1]);
                end
            end
        end
    endtask

    task automatic test_burst_wait();
        logic [1:0] t1  [7] = '{TRANS_NONSEQ, TRANS_SEQ, TRANS_SEQ, TRANS_SEQ, TRANS_SEQ, TRANS_SEQ, TRANS_IDLE};
        bit         rdy [7] = '{1, 0, 0, 1, 1, 1, 1};
        int         ex  [7] = '{1, 1, 1, 1, 1, 1, 2};
        int a, dp;
        bit n, dv;
        do_reset();
        drive(2, 1'b1, TRANS_NONSEQ, BURST_SINGLE, 1'b0);
        for (int c = 0; c < 7; c++) begin
            drive(1, (c < 6), t1[c], BURST_INCR4, 1'b0);
            bus.HREADYM = rdy[c];
            cycle("burst_wait", a, n, dp, dv);
            checks++;
            if (a !== ex[c] || n !== 1'b0) begin
                errors++;
                $display("FAIL burst_grant[%0d]: addr_in_port=%0d expected %0d", c, a, ex[c]);
            end
            if (c > 0) begin
                checks++;
                if (dp !== 1 || dv !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_hold_data[%0d]: data_in_port=%0d expected 1", c, dp);
                end
            end
        end
        bus.HREADYM = 1'b1;
    endtask

    task automatic test_lock();
        logic [1:0] t0  [5] = '{TRANS_NONSEQ, TRANS_IDLE, TRANS_NONSEQ, TRANS_NONSEQ, TRANS_IDLE};
        bit         l0  [5] = '{1, 1, 1, 0, 0};
        bit         s1  [5] = '{0, 1, 1, 1, 1};
        int         ex  [5] = '{0, 0, 0, 0, 1};
        int a, dp;
        bit n, dv;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(0, 1'b1, t0[c], BURST_SINGLE, l0[c]);
            drive(1, s1[c], TRANS_NONSEQ, BURST_SINGLE, 1'b0);
            cycle("lock", a, n, dp, dv);
            checks++;
            if (a !== ex[c] || n !== 1'b0) begin
                errors++;
                $display("FAIL lock_grant[%0d]: addr_in_port=%0d no_port=%0b expected %0d/0", c, a, n, ex[c]);
            end
            if (c == 1) begin
                checks++;
                if (bus.active_op !== 3'b001) begin
                    errors++;
                    $display("FAIL lock_idle_active: active_op=%b expected 001", bus.active_op);
                end
            end
        end
    endtask

    task automatic test_burst_hold();
        logic [1:0] t2 [10] = '{TRANS_NONSEQ, TRANS_SEQ, TRANS_SEQ, TRANS_IDLE, TRANS_SEQ,
                                TRANS_SEQ, TRANS_SEQ, TRANS_SEQ, TRANS_SEQ, TRANS_IDLE};
        int a, dp;
        bit n, dv;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(2, 1'b1, t2[c], BURST_WRAP8, 1'b0);
            drive(0, (c > 0), TRANS_NONSEQ, BURST_SINGLE, 1'b0);
            cycle("burst_hold", a, n, dp, dv);
            if (c == 3) begin
                checks++;
                if (a !== (BH ? 2 : 0)) begin
                    errors++;
                    $display("FAIL wrap8_idle: addr_in_port=%0d expected %0d", a, BH ? 2 : 0);
                end
            end
            if (BH && c == 9) begin
                checks++;
                if (a !== 0) begin
                    errors++;
                    $display("FAIL wrap8_release: addr_in_port=%0d expected 0", a);
                end
            end
        end
    endtask

    task automatic test_random();
        int a, dp;
        bit n, dv;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                drive(i, ($urandom % 4) != 0, 2'($urandom), 3'($urandom), ($urandom % 4) == 0);
            end
            bus.HREADYM = ($urandom % 5) != 0;
            cycle("random", a, n, dp, dv);
        end
        bus.HREADYM = 1'b1;
    endtask

    task automatic test_async_reset();
        int ex [3] = '{1, 2, 0};
        int a, dp;
        bit n, dv;
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, TRANS_NONSEQ, BURST_SINGLE, 1'b0);
        drive(1, 1'b1, TRANS_NONSEQ, BURST_INCR4, 1'b0);
        cycle("async_pre", a, n, dp, dv);
        drive(1, 1'b1, TRANS_SEQ, BURST_INCR4, 1'b0);
        cycle("async_pre", a, n, dp, dv);
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.data_valid !== 1'b0 || bus.data_in_port !== '0 || bus.addr_in_port !== 2'd1) begin
            errors++;
            $display("FAIL async_reset: data_valid=%0b data_in_port=%0d addr_in_port=%0d, expected 0/0/1",
                     bus.data_valid, bus.data_in_port, bus.addr_in_port);
        end
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        for (int i = 0; i < N; i++) drive(i, 1'b1, TRANS_NONSEQ, BURST_SINGLE, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cycle("post_reset", a, n, dp, dv);
            checks++;
            if (a !== ex[c]) begin
                errors++;
                $display("FAIL post_reset_order[%0d]: addr_in_port=%0d expected %0d", c, a, ex[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_wait();
        test_lock();
        test_burst_hold();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/l1mtx_out_arb.md
# l1mtx_out_arb

Round-robin arbiter for one output stage of the L1MTX AHB bus matrix. It shares a single output port (slave) between up to NUM_IN input stages. It grants one input stage per address phase and holds the grant through locked sequences and SEQ/BUSY beats. It drives each input stage's decoder `active` input, plus the address-phase and data-phase port selects used by the output-stage muxes.

## Interface
Parameters:
- NUM_IN, 3, number of input stages competing for this output port (2..8)
- IDX_W, $clog2(NUM_IN), width of port index

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  reset, asynchronous, active-low
- HREADYM  in  1  HREADY of the output port; arbitration state advances only when 1
- sel_op  in  NUM_IN  per-input select from that input stage's decoder (sel_decN)
- trans_op  in  2*NUM_IN  per-input HTRANS, input i at [2i+1:2i]
- burst_op  in  3*NUM_IN  per-input HBURST
- mastlock_op  in  NUM_IN  per-input HMASTLOCK
- addr_in_port  out  IDX_W  combinational address-phase owner index
- no_port  out  1  combinational; 1 = no input owns the address phase (drive IDLE)
- active_op  out  NUM_IN  combinational one-hot; bit i = addr_in_port==i & ~no_port
- data_in_port  out  IDX_W  registered data-phase owner index
- data_valid  out  1  registered; 1 = data phase belongs to data_in_port

## Operation
- req[i] = sel_op[i] & trans_op[i][1] (NONSEQ or SEQ).
- Registered state: grant_q (IDX_W), owned_q (1), lock_q (1), rr_ptr (IDX_W).
- Hold is true when:
  - owned_q & sel_op[grant_q] & trans_op[grant_q] ∈ {BUSY, SEQ}, or
  - owned_q & lock_q & sel_op[grant_q].
- When hold is true, the next owner is grant_q and the next no_port is 0.
- Otherwise, when any req is set, the next owner is the first i with req[i], scanning rr_ptr+1, rr_ptr+2, … modulo NUM_IN. The scan wraps, so index NUM_IN-1 is followed by 0.
- Otherwise, the next owner is grant_q and the next no_port is 1.
- addr_in_port and no_port present these next values combinationally.
- On HCLK rising edge with HREADYM=1:
  - grant_q ← addr_in_port.
  - owned_q ← ~no_port.
  - lock_q ← mastlock_op[addr_in_port] & ~no_port.
  - rr_ptr ← addr_in_port only when a new grant was made, meaning not a hold and no_port=0.
  - data_in_port ← addr_in_port.
  - data_valid ← ~no_port.
- With HREADYM=0, all registered state holds.
- When the owner drops sel_op mid-burst, hold releases and re-arbitration happens in the same cycle.
- When a locked owner issues IDLE with mastlock still high, the grant stays with that owner: no_port=0 and active_op stays set, so no other input is granted.
- Simultaneous requests from all inputs at reset are served in the order 1, 2, …, NUM_IN-1, 0, because rr_ptr starts at 0.

## Timing
- Address-phase select has zero latency: a request is combinationally visible on active_op in the same cycle.
- The data-phase select follows one HREADYM-qualified edge later.
- Reset values:
  - grant_q=0, owned_q=0, lock_q=0, rr_ptr=0
  - data_in_port=0, data_valid=0
  - hence no_port=1 and active_op=0 with no requests
- Reset asserted mid-burst clears ownership immediately and asynchronously. The first cycle after release arbitrates from rr_ptr=0.
- Waited states (HREADYM=0) freeze grant_q. The addr_in_port output may still change only if hold is false.

## Configuration
- L1MTX_ARB_BURST_HOLD_EN defined:
  - Adds a 5-bit beat counter, loaded on each new grant.
  - Load values by burst type: INCR4/WRAP4 → 3, INCR8/WRAP8 → 7, INCR16/WRAP16 → 15, SINGLE/INCR → 0.
  - The counter decrements on each HREADYM-qualified SEQ beat of the owner.
  - Hold is also true while count≠0 & owned_q & sel_op[grant_q], even during IDLE, so a defined-length burst cannot be interleaved.
- Undefined: no counter; hold is exactly as described under Operation.

## Structure
- Shared package l1mtx_pkg holds:
  - HTRANS encodings: TRANS_IDLE, TRANS_BUSY, TRANS_NONSEQ, TRANS_SEQ
  - HBURST encodings
  - the function burst_beats(burst) returning the counter load value
- Round-robin pick is a natural sub-module, l1mtx_rr_pick: combinational, with inputs req and ptr and outputs idx and any.

## Test plan
- Reset, no requests → no_port=1, active_op=0, data_valid=0 on the first post-reset edge.
- NUM_IN=3, req from inputs 0,1,2 every cycle as single NONSEQ, HREADYM=1 → grant sequence 1,2,0,1…; data_in_port lags by one cycle.
- Input 1 runs INCR4 (NONSEQ, SEQ×3) while input 2 requests → input 2 is granted only after the 4th beat. Insert HREADYM=0 for 2 cycles mid-burst → grant_q is unchanged.
- Input 0 with mastlock=1, NONSEQ, IDLE, NONSEQ; input 1 requesting throughout → input 1 is not granted until input 0 issues a transfer with mastlock=0.
- With L1MTX_ARB_BURST_HOLD_EN: input 2 runs WRAP8 with IDLE inserted after beat 3 → the grant stays with 2 until 8 beats complete. Without the macro, the grant moves to the competing input at the IDLE.
- Assert HRESETn low during a burst → outputs return to reset values asynchronously; after release, rr_ptr=0 order resumes.
